// File: rtl/monobit_stream_gen.sv
// Framed serial bit-stream source for monobit test input: LFSR / all-ones /
// alternating / biased patterns over valid-ready with last-bit framing and a ones count.
module monobit_stream_gen #(
    parameter int unsigned BLOCK_LEN = 128,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    input  logic                               start,
    input  logic [1:0]                         mode,
    input  logic [3:0]                         bias,
    output logic                               bit_out,
    output logic                               bit_valid,
    input  logic                               bit_ready,
    output logic                               bit_last,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(BLOCK_LEN+1)-1:0]     ones_count
);

    localparam int unsigned CW       = $clog2(BLOCK_LEN + 1);
    localparam int unsigned IW       = $clog2(BLOCK_LEN);
    localparam logic [31:0] SEED     = (LFSR_SEED == '0) ? 32'h1 : LFSR_SEED;
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [31:0]     r_lfsr;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_ones;
    logic [1:0]      r_mode;
    logic [3:0]      r_bias;
    logic            r_phase;

    logic            w_start;
    logic            w_xfer;
    logic            w_is_last;
    logic            w_bit;
    logic [31:0]     w_lfsr_next;

    assign w_start     = ena & start & (r_state == IDLE);
    assign w_xfer      = ena & bit_ready & (r_state == RUN);
    assign w_is_last   = (r_idx == LAST_IDX);
    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : '0);
    assign ones_count  = r_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (ena) begin
            case (r_state)
                IDLE:    if (start) w_next_state = RUN;
                RUN:     if (bit_ready && w_is_last) w_next_state = DONE;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_bit = 1'b0;
        case (r_mode)
            2'b00:   w_bit = r_lfsr[0];
            2'b01:   w_bit = 1'b1;
            2'b10:   w_bit = r_phase;
            default: w_bit = (r_lfsr[3:0] < r_bias);
        endcase
    end

    // Outputs decode only registered state, so bit_ready never reaches bit_valid.
    always_comb begin
        bit_valid = (r_state == RUN);
        bit_out   = (r_state == RUN) & w_bit;
        bit_last  = (r_state == RUN) & w_is_last;
        busy      = (r_state == RUN) | (r_state == DONE);
        done      = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr  <= SEED;
            r_idx   <= '0;
            r_ones  <= '0;
            r_mode  <= '0;
            r_bias  <= '0;
            r_phase <= 1'b1;
        end else if (w_start) begin
            r_idx   <= '0;
            r_ones  <= '0;
            r_mode  <= mode;
            r_bias  <= bias;
            r_phase <= 1'b1;
        end else if (w_xfer) begin
            r_idx   <= r_idx + IW'(1);
            r_ones  <= r_ones + CW'(w_bit);
            r_lfsr  <= w_lfsr_next;
            r_phase <= ~r_phase;
        end
    end

endmodule

// File: tb/tb_monobit_stream_gen.sv
// Directed/randomized bench for monobit_stream_gen against a behavioural bit-sequence model.
module tb_monobit_stream_gen;

    localparam int unsigned LEN  = 128;
    localparam int unsigned CW   = $clog2(LEN + 1);
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          start;
    logic [1:0]    mode;
    logic [3:0]    bias;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_last;
    logic          busy;
    logic          done;
    logic [CW-1:0] ones_count;

    int            n_checks;
    int            n_pass;
    logic [31:0]   m_lfsr;
    logic [LEN-1:0] obs_bits;
    logic [LEN-1:0] ref_bits;
    logic [CW-1:0] obs_ones;
    logic [CW-1:0] ref_ones;

    monobit_stream_gen #(.BLOCK_LEN(LEN), .LFSR_SEED(SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .mode       (mode),
        .bias       (bias),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_last   (bit_last),
        .busy       (busy),
        .done       (done),
        .ones_count (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] lf);
        return (lf >> 1) ^ ((lf % 2 == 1) ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic model_bit(input logic [1:0] md, input logic [3:0] bs,
                                       input logic [31:0] lf, input int k);
        case (md)
            2'd0:    return lf[0];
            2'd1:    return 1'b1;
            2'd2:    return (k % 2) == 0;
            default: return (lf % 16) < 32'(bs);
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = SEED;
    endtask

    task automatic run_block(input logic [1:0] md, input logic [3:0] bs, input bit rnd,
                             input int glitch_at, input int abort_at);
        logic [31:0] lf;
        logic        exp_bit;
        logic        xfer;
        int          k;
        int          ones;
        int          cyc;
        bit          glitched;
        lf = m_lfsr; k = 0; ones = 0; cyc = 0; glitched = 0;
        mode = md; bias = bs; start = 1'b1; ena = 1'b1; bit_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("valid_after_start", bit_valid, 1);
        while (k < LEN && cyc < 4000) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_bit_out", bit_out, 0);
                check("abort_valid", bit_valid, 0);
                check("abort_last", bit_last, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_ones", ones_count, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                end
                rst_n = 1'b1;
                m_lfsr = SEED;
                return;
            end
            exp_bit = model_bit(md, bs, lf, k);
            check("bit_out", bit_out, exp_bit);
            check("bit_valid", bit_valid, 1);
            check("bit_last", bit_last, (k == LEN - 1));
            check("ones_running", ones_count, ones);
            check("done_in_run", done, 0);
            obs_bits[k] = bit_out;
            start = 1'b0;
            if (k == glitch_at && !glitched) begin
                start = 1'b1; mode = ~md; bias = ~bs; glitched = 1;
            end
            if (rnd) begin
                ena = ($urandom_range(0, 3) != 0);
                bit_ready = 1'($urandom_range(0, 1));
            end else begin
                ena = 1'b1; bit_ready = 1'b1;
            end
            xfer = ena & bit_ready;
            @(negedge clk);
            cyc++;
            if (xfer) begin
                ones += int'(exp_bit);
                lf = lfsr_next(lf);
                k++;
            end
        end
        start = 1'b0; ena = 1'b1; bit_ready = 1'b0;
        m_lfsr = lf;
        if (k < LEN) begin
            check("block_timeout", k, LEN);
            return;
        end
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("valid_in_done", bit_valid, 0);
        check("last_in_done", bit_last, 0);
        check("ones_final", ones_count, ones);
        obs_ones = ones_count;
        @(negedge clk);
        check("done_cleared", done, 0);
        check("busy_cleared", busy, 0);
        check("ones_hold", ones_count, ones);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; mode = '0; bias = '0; bit_ready = 1'b0;
        m_lfsr = SEED;
        repeat (3) @(negedge clk);
        check("rst_bit_out", bit_out, 0);
        check("rst_valid", bit_valid, 0);
        check("rst_last", bit_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ones", ones_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_block(2'd0, 4'd0, 0, -1, -1);
        check("seed_bit0", obs_bits[0], 0);

        run_block(2'd1, 4'd0, 0, -1, -1);
        check("allones_count", obs_ones, 128);
        check("allones_bits", obs_bits, {LEN{1'b1}});

        run_block(2'd2, 4'd0, 0, -1, -1);
        check("alt_count", obs_ones, 64);
        run_block(2'd3, 4'd0, 0, -1, -1);
        check("bias0_count", obs_ones, 0);
        run_block(2'd3, 4'd15, 0, -1, -1);

        do_reset();
        run_block(2'd0, 4'd0, 0, -1, -1);
        ref_bits = obs_bits;
        ref_ones = obs_ones;
        do_reset();
        run_block(2'd0, 4'd0, 1, -1, -1);
        check("bp_sequence", obs_bits, ref_bits);
        check("bp_ones", obs_ones, ref_ones);

        run_block(2'd1, 4'd0, 0, 40, -1);
        check("ignored_start_count", obs_ones, 128);
        run_block(2'd2, 4'd0, 0, -1, -1);
        check("next_mode_count", obs_ones, 64);

        run_block(2'd0, 4'd0, 0, -1, 50);
        @(negedge clk);
        run_block(2'd0, 4'd0, 0, -1, -1);
        check("reseed_sequence", obs_bits, ref_bits);
        check("reseed_ones", obs_ones, ref_ones);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/monobit_stream_gen.md
# monobit_stream_gen

Framed serial bit-stream source that drives the monobit (frequency) test input. It generates blocks of `BLOCK_LEN` bits from a selectable pattern: a 32-bit Galois LFSR, all-ones, alternating, or LFSR-derived biased. Bits are delivered over a valid/ready handshake with last-bit framing. It also keeps a running ones count, so the consumer's result can be checked against a known-good value on-chip or in the bench.

## Interface

Parameters:
- `BLOCK_LEN`, 128: bits per block; legal range ≥ 2.
- `LFSR_SEED`, 32'hACE1_2468: LFSR reset value; a value of 0 is replaced by 32'h1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ena`  in  1  enable; when low, all state freezes and no transfer occurs.
- `start`  in  1  begin block; sampled only in IDLE.
- `mode`  in  2  pattern select: 00 LFSR, 01 all-ones, 10 alternating, 11 biased.
- `bias`  in  4  biased mode only: bit = (lfsr[3:0] < bias).
- `bit_out`  out  1  current bit.
- `bit_valid`  out  1  `bit_out` is valid.
- `bit_ready`  in  1  consumer accepts the bit.
- `bit_last`  out  1  current bit is the final bit of the block.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse after the last transfer.
- `ones_count`  out  W  ones emitted in the current or last block; W = $clog2(BLOCK_LEN+1).

## Operation

- FSM states: IDLE, RUN, DONE. All transitions require `ena`=1.
- IDLE → RUN:
  - Condition: `start`=1.
  - Actions: latch `mode` and `bias`, clear bit index and `ones_count`, clear alternating phase to 1.
- Transfer: defined as `bit_valid & bit_ready & ena`. On each transfer:
  - bit index increments.
  - `ones_count` += `bit_out`.
  - LFSR advances (in every mode).
  - Alternating phase toggles.
- RUN → DONE: on the transfer of the bit with index `BLOCK_LEN-1`.
- DONE → IDLE: unconditional after one cycle; `done`=1 only in DONE.
- `bit_out` by mode:
  - 00: lfsr[0].
  - 01: 1.
  - 10: phase, so each block starts 1,0,1,0…
  - 11: lfsr[3:0] < latched `bias`. `bias`=0 gives all zeros; `bias`=15 gives a 15/16 ones density.
- LFSR:
  - Update: Galois right shift, next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 0), i.e. taps 32, 22, 2, 1.
  - Not reseeded between blocks; only reset reloads the seed.
- `bit_last` = `bit_valid` & (index == `BLOCK_LEN-1`).
- Ignored inputs:
  - `start` in RUN or DONE.
  - Changes to `mode`/`bias` after latching.
- Stall: while `bit_valid`=1 and no transfer occurs, `bit_out`, `bit_last` and `ones_count` hold stable.
- `ones_count` holds its final value from DONE until the next accepted `start`.
- `ena`=0: no state, LFSR, counter or output change. `bit_valid` keeps its value, but no transfer counts.

## Timing

- Reset (async, immediate): state IDLE, LFSR = seed, index 0. `bit_out`, `bit_valid`, `bit_last`, `busy`, `done` and `ones_count` are all 0.
- `start` accepted at edge N: `busy` and `bit_valid` are high after edge N, and the first bit is presented in cycle N+1.
- With `bit_ready` held at 1, one bit transfers per cycle. The last transfer happens at edge N+`BLOCK_LEN`. `done` is high for the cycle after that edge, then `busy` drops at the following edge.
- Minimum spacing between block starts is `BLOCK_LEN`+2 edges, since `start` is honoured only back in IDLE.
- Reset asserted mid-block: the block is abandoned, outputs clear at once, and no `done` pulse is issued.
- All outputs are registered or decoded only from registered state; no combinational path from `bit_ready` to `bit_valid`.

## Test plan

- **Reset/seed:** assert `rst_n`=0 with the clock running → all outputs 0. Release, then `start` in mode 00 → the first bit equals seed[0]=0. The first 32 bits match a Galois model seeded with 32'hACE1_2468.
- **All-ones:** mode 01, `bit_ready`=1, `BLOCK_LEN`=128 → 128 consecutive 1s. `bit_last` is high only on bit 128. `done` pulses once, the cycle after. `ones_count`=128.
- **Alternating / bias extremes:**
  - mode 10 → 1,0,1,… and `ones_count`=64.
  - mode 11, `bias`=0 → `ones_count`=0.
  - mode 11, `bias`=15 → `ones_count` equals the model's value.
- **Backpressure:** mode 00 with `bit_ready` randomly toggled and `ena` randomly dropped → `bit_out`/`bit_last` stable across stalls. The bit sequence and final `ones_count` are identical to a run with `bit_ready`=1.
- **Ignored start:** pulse `start` with `mode` changed at bit 40 of a block → no restart and no mode change. The block completes with the original count; the next start obeys the new mode.
- **Mid-block reset:** assert `rst_n`=0 at bit 50 → outputs 0 asynchronously and no `done`. After release and `start`, the LFSR sequence restarts from the seed.
